operand_fetch: RTL
==================

# operand_fetch

Operand-fetch stage between the instruction decoder and the execute stage. It drives the register file read addresses, selects each source operand from the register file or a forwarded EX/MEM/WB result, and detects load-use hazards. Resolved operands and control are registered into the ID/EX pipeline register behind a valid/ready handshake. A saturating counter records load-use stall cycles.

## Interface
- XLEN, 32, datapath width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- flush  in  1  kill the instruction in the stage and the ID/EX register
- in_valid  in  1  decoder presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_pc  in  32  instruction PC
- in_rs1, in_rs2  in  5  source register indices
- in_use_rs1, in_use_rs2  in  1  source is actually read
- in_rd  in  5  destination index
- in_rd_we  in  1  instruction writes rd
- in_is_load  in  1  instruction is a load
- raddr_rs1, raddr_rs2  out  5  register file read addresses
- rdata_rs1, rdata_rs2  in  XLEN  register file read data, combinational from raddr
- ex_result  in  XLEN  ALU result of the instruction held in the ID/EX register
- mem_rd  in  5; mem_we  in  1; mem_result  in  XLEN  MEM-stage writer
- wb_rd  in  5; wb_we  in  1; wb_data  in  XLEN  WB-stage writer, same as register file write port
- out_valid  out  1  ID/EX register holds an instruction
- out_ready  in  1  execute accepts it
- out_pc  out  32; out_rs1_val, out_rs2_val  out  XLEN; out_rd  out  5; out_rd_we, out_is_load  out  1
- stall_cnt  out  32  load-use stall cycles, saturating

## Operation
- raddr_rs1/raddr_rs2 equal in_rs1/in_rs2 combinationally.
- Operand select per source, first match wins, index 0 always yields 0:
  - EX: out_valid & out_rd_we & !out_is_load & out_rd==rs → ex_result
  - MEM: mem_we & mem_rd==rs → mem_result
  - WB: wb_we & wb_rd==rs → wb_data
  - otherwise the register file value
- Load-use hazard: in_valid & out_valid & out_is_load & out_rd_we & out_rd!=0 & ((in_use_rs1 & in_rs1==out_rd) | (in_use_rs2 & in_rs2==out_rd)).
- adv = !out_valid | out_ready.
- in_ready = adv & !hazard & !flush.
- On a clock edge:
  - flush → out_valid←0, other outputs hold.
  - else in_valid & in_ready → capture all out_* fields, out_valid←1.
  - else adv → out_valid←0, a bubble.
  - else hold everything.
- stall_cnt increments on every edge where in_valid & hazard & !flush. It holds at 0xFFFF_FFFF.

## Timing
- Reset, asynchronous: out_valid=0, out_pc=0, out_rs1_val=0, out_rs2_val=0, out_rd=0, out_rd_we=0, out_is_load=0, stall_cnt=0. While rst_n=0, in_ready=1.
- Latency is 1 cycle from in_valid&in_ready to out_valid. Throughput is 1 per cycle when there is no hazard and out_ready=1.
- A load-use hazard costs exactly one bubble. On the next cycle the load is in MEM and the operand is forwarded from mem_result.
- While out_valid=1 and out_ready=0, every out_* field stays bit-stable and in_ready=0.
- Forwarded values are sampled only at capture. A held ID/EX entry is never re-evaluated.
- flush together with in_valid: the instruction is not accepted, and the next cycle has out_valid=0.
- A WB write to the same register in the capture cycle is always taken from wb_data. There is no dependence on register file write-through.
- rst_n falling mid-transfer clears the entry immediately. There is no partial capture.

## Test plan
- Reset: rst_n=0 with out_* garbage driven → out_valid=0, all outputs 0, in_ready=1. Release, then idle → state unchanged.
- Plain read: register file x5=0x0000_1234, no forwarding; issue rs1=5, rs2=0 → next cycle out_rs1_val=0x1234, out_rs2_val=0, out_valid=1.
- Priority: rs1=3 with ex (non-load, rd=3) =0xA, mem_rd=3 =0xB, wb_rd=3 =0xC, register file=0xD → 0xA. Retry without EX → 0xB, then 0xC, then 0xD. rs1=0 with every stage writing x0 → 0.
- Load-use: ID/EX holds a load to x7, out_ready=1, issue rs2=7 with in_use_rs2=1 → in_ready=0, next cycle out_valid=0 and stall_cnt=1. The cycle after, mem_result=0x55 → out_rs2_val=0x55. The same sequence with in_use_rs2=0 → no stall.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → out_* stable, in_ready=0, stall_cnt unchanged. out_ready=1 → the next instruction is captured.
- Flush and async reset: flush with in_valid=1 → not accepted, out_valid=0. Assert rst_n low mid-cycle → outputs zero before the next edge. Force stall_cnt near saturation → it sticks at 0xFFFF_FFFF.

Source files
------------

// File: rtl/operand_fetch_if.sv
// -----------------------------------------------------------------------------
// operand_fetch_if
//   Bundles every non-clock signal of the operand-fetch stage.
//   master : environment side (decoder, register file, later stages)
//   slave  : the operand_fetch stage itself
//
//   Decoder side    : flush, in_valid/in_ready, in_pc, in_rs1/2, in_use_rs1/2,
//                     in_rd, in_rd_we, in_is_load
//   Register file   : raddr_rs1/2 (to file), rdata_rs1/2 (from file)
//   Forwarding      : ex_result, mem_rd/mem_we/mem_result, wb_rd/wb_we/wb_data
//   ID/EX register  : out_valid/out_ready, out_pc, out_rs1_val, out_rs2_val,
//                     out_rd, out_rd_we, out_is_load
//   Statistics      : stall_cnt
// -----------------------------------------------------------------------------
interface operand_fetch_if #(
   parameter int XLEN = 32
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_pc;
   logic [4:0]      in_rs1;
   logic [4:0]      in_rs2;
   logic            in_use_rs1;
   logic            in_use_rs2;
   logic [4:0]      in_rd;
   logic            in_rd_we;
   logic            in_is_load;

   logic [4:0]      raddr_rs1;
   logic [4:0]      raddr_rs2;
   logic [XLEN-1:0] rdata_rs1;
   logic [XLEN-1:0] rdata_rs2;

   logic [XLEN-1:0] ex_result;
   logic [4:0]      mem_rd;
   logic            mem_we;
   logic [XLEN-1:0] mem_result;
   logic [4:0]      wb_rd;
   logic            wb_we;
   logic [XLEN-1:0] wb_data;

   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_pc;
   logic [XLEN-1:0] out_rs1_val;
   logic [XLEN-1:0] out_rs2_val;
   logic [4:0]      out_rd;
   logic            out_rd_we;
   logic            out_is_load;

   logic [31:0]     stall_cnt;

   modport master (
      output flush, in_valid, in_pc, in_rs1, in_rs2, in_use_rs1, in_use_rs2,
             in_rd, in_rd_we, in_is_load,
      input  in_ready,
      input  raddr_rs1, raddr_rs2,
      output rdata_rs1, rdata_rs2,
      output ex_result, mem_rd, mem_we, mem_result, wb_rd, wb_we, wb_data,
      input  out_valid, out_pc, out_rs1_val, out_rs2_val, out_rd, out_rd_we,
             out_is_load,
      output out_ready,
      input  stall_cnt
   );

   modport slave (
      input  flush, in_valid, in_pc, in_rs1, in_rs2, in_use_rs1, in_use_rs2,
             in_rd, in_rd_we, in_is_load,
      output in_ready,
      output raddr_rs1, raddr_rs2,
      input  rdata_rs1, rdata_rs2,
      input  ex_result, mem_rd, mem_we, mem_result, wb_rd, wb_we, wb_data,
      output out_valid, out_pc, out_rs1_val, out_rs2_val, out_rd, out_rd_we,
             out_is_load,
      input  out_ready,
      output stall_cnt
   );
endinterface

// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch
//   Operand-fetch stage between decode and execute. Drives the register file
//   read addresses, resolves each source operand from the register file or a
//   forwarded EX/MEM/WB result, detects load-use hazards and registers the
//   resolved instruction into the ID/EX register behind a valid/ready
//   handshake. A saturating counter records load-use stall cycles.
//
//   Ports
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     bus    : operand_fetch_if.slave (decoder handshake, register file read
//              port, forwarding sources, ID/EX outputs, stall counter)
// -----------------------------------------------------------------------------
module operand_fetch #(
   parameter int XLEN = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   operand_fetch_if.slave bus
);

   localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

   // First match wins; x0 is hard-wired to zero whatever the sources say.
   function automatic logic [XLEN-1:0] select_operand(
      input logic [4:0]      rs,
      input logic            ex_en,
      input logic [4:0]      ex_rd,
      input logic [XLEN-1:0] ex_val,
      input logic            mem_en,
      input logic [4:0]      mem_rd,
      input logic [XLEN-1:0] mem_val,
      input logic            wb_en,
      input logic [4:0]      wb_rd,
      input logic [XLEN-1:0] wb_val,
      input logic [XLEN-1:0] rf_val
   );
      logic [XLEN-1:0] val;
      if (rs == 5'd0)
         val = '0;
      else if (ex_en && (ex_rd == rs))
         val = ex_val;
      else if (mem_en && (mem_rd == rs))
         val = mem_val;
      else if (wb_en && (wb_rd == rs))
         val = wb_val;
      else
         val = rf_val;
      return val;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
      return (cnt == CNT_MAX) ? cnt : cnt + 32'd1;
   endfunction

   logic            vld_p1;
   logic [31:0]     pc_p1;
   logic [XLEN-1:0] rs1_val_p1;
   logic [XLEN-1:0] rs2_val_p1;
   logic [4:0]      rd_p1;
   logic            rd_we_p1;
   logic            is_load_p1;
   logic [31:0]     stall_cnt_q;

   logic [XLEN-1:0] rs1_val_p0;
   logic [XLEN-1:0] rs2_val_p0;
   logic            ex_fwd_en;
   logic            src_hit;
   logic            hazard;
   logic            adv;
   logic            in_rdy;
   logic            accept;

   // ---- p0: operand resolution, hazard detection, handshake ----
   assign bus.raddr_rs1 = bus.in_rs1;
   assign bus.raddr_rs2 = bus.in_rs2;

   // A load in ID/EX has no data yet, so ex_result is only usable for non-loads.
   assign ex_fwd_en = vld_p1 & rd_we_p1 & ~is_load_p1;

   assign rs1_val_p0 = select_operand(bus.in_rs1, ex_fwd_en, rd_p1, bus.ex_result,
                                      bus.mem_we, bus.mem_rd, bus.mem_result,
                                      bus.wb_we, bus.wb_rd, bus.wb_data,
                                      bus.rdata_rs1);
   assign rs2_val_p0 = select_operand(bus.in_rs2, ex_fwd_en, rd_p1, bus.ex_result,
                                      bus.mem_we, bus.mem_rd, bus.mem_result,
                                      bus.wb_we, bus.wb_rd, bus.wb_data,
                                      bus.rdata_rs2);

   assign src_hit = (bus.in_use_rs1 & (bus.in_rs1 == rd_p1)) |
                    (bus.in_use_rs2 & (bus.in_rs2 == rd_p1));
   assign hazard  = bus.in_valid & vld_p1 & is_load_p1 & rd_we_p1 &
                    (rd_p1 != 5'd0) & src_hit;

   assign adv    = ~vld_p1 | bus.out_ready;
   // While held in reset the stage advertises readiness regardless of flush.
   assign in_rdy = ~rst_n | (adv & ~hazard & ~bus.flush);
   assign accept = bus.in_valid & in_rdy;

   assign bus.in_ready = in_rdy;

   // ---- p1: ID/EX register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1     <= 1'b0;
         pc_p1      <= '0;
         rs1_val_p1 <= '0;
         rs2_val_p1 <= '0;
         rd_p1      <= '0;
         rd_we_p1   <= 1'b0;
         is_load_p1 <= 1'b0;
      end else if (bus.flush) begin
         vld_p1 <= 1'b0;
      end else if (accept) begin
         vld_p1     <= 1'b1;
         pc_p1      <= bus.in_pc;
         rs1_val_p1 <= rs1_val_p0;
         rs2_val_p1 <= rs2_val_p0;
         rd_p1      <= bus.in_rd;
         rd_we_p1   <= bus.in_rd_we;
         is_load_p1 <= bus.in_is_load;
      end else if (adv) begin
         vld_p1 <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt_q <= '0;
      else if (hazard & ~bus.flush)
         stall_cnt_q <= sat_inc(stall_cnt_q);
   end

   assign bus.out_valid   = vld_p1;
   assign bus.out_pc      = pc_p1;
   assign bus.out_rs1_val = rs1_val_p1;
   assign bus.out_rs2_val = rs2_val_p1;
   assign bus.out_rd      = rd_p1;
   assign bus.out_rd_we   = rd_we_p1;
   assign bus.out_is_load = is_load_p1;
   assign bus.stall_cnt   = stall_cnt_q;

endmodule
